// File: rtl/lsu_ctrl_if.sv
// Bundle of the EX request, MA access and WB result channels around lsu_ctrl.
// slave is the sequencer's view; master is the view of the surrounding pipeline.
interface lsu_ctrl_if;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_ctrl;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic [31:0] ma_addr;
    logic [31:0] ma_dataW;
    logic [2:0]  ma_ctrl;
    logic        ma_memR;
    logic        ma_memW;
    logic [31:0] ma_dataR;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  wb_err;

    modport slave (
        input  flush, req_valid, req_store, req_ctrl, req_addr, req_wdata, req_rd,
        input  ma_dataR, wb_ready,
        output req_ready, ma_addr, ma_dataW, ma_ctrl, ma_memR, ma_memW,
        output wb_valid, wb_we, wb_rd, wb_data, wb_err
    );

    modport master (
        output flush, req_valid, req_store, req_ctrl, req_addr, req_wdata, req_rd,
        output ma_dataR, wb_ready,
        input  req_ready, ma_addr, ma_dataW, ma_ctrl, ma_memR, ma_memW,
        input  wb_valid, wb_we, wb_rd, wb_data, wb_err
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer feeding the MA stage: one request in flight, legality and
// alignment checks, one-cycle memory strobe, read-latency wait, held WB result.
module lsu_ctrl #(
    parameter int READ_LAT    = 1,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    lsu_ctrl_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_MIS = 2'b01;
    localparam logic [1:0] ERR_ILL = 2'b10;

    localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

    logic [1:0]  state_reg, state_next;
    logic        store_reg, store_next;
    logic [2:0]  ctrl_reg, ctrl_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [4:0]  rd_reg, rd_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic        wb_we_reg, wb_we_next;
    logic [4:0]  wb_rd_reg, wb_rd_next;
    logic [31:0] wb_data_reg, wb_data_next;
    logic [1:0]  wb_err_reg, wb_err_next;

    logic        req_ready_int;
    logic        accept;
    logic        illegal;
    logic        misaligned;
    logic [1:0]  req_err;
    logic        in_access;
    logic        in_resp;

    always_comb begin
        req_ready_int = ((state_reg == S_IDLE) || ((state_reg == S_RESP) && bus.wb_ready))
                        && !bus.flush && !rst;
        accept = bus.req_valid && req_ready_int;

        if (bus.req_store)
            illegal = !((bus.req_ctrl == 3'b000) || (bus.req_ctrl == 3'b001) ||
                        (bus.req_ctrl == 3'b010));
        else
            illegal = (bus.req_ctrl == 3'b011) || (bus.req_ctrl == 3'b110) ||
                      (bus.req_ctrl == 3'b111);

        // ctrl[1:0]==01 covers both h and hu
        misaligned = CHECK_ALIGN &&
                     (((bus.req_ctrl[1:0] == 2'b01) && bus.req_addr[0]) ||
                      ((bus.req_ctrl == 3'b010) && (bus.req_addr[1:0] != 2'b00)));

        if (illegal)
            req_err = ERR_ILL;
        else if (misaligned)
            req_err = ERR_MIS;
        else
            req_err = ERR_OK;
    end

    always_comb begin
        state_next   = state_reg;
        store_next   = store_reg;
        ctrl_next    = ctrl_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        rd_next      = rd_reg;
        cnt_next     = cnt_reg;
        wb_we_next   = wb_we_reg;
        wb_rd_next   = wb_rd_reg;
        wb_data_next = wb_data_reg;
        wb_err_next  = wb_err_reg;

        case (state_reg)
            S_ACCESS: begin
                if (store_reg) begin
                    state_next   = S_RESP;
                    wb_we_next   = 1'b0;
                    wb_rd_next   = 5'd0;
                    wb_data_next = 32'd0;
                    wb_err_next  = ERR_OK;
                end else begin
                    state_next = S_WAIT;
                    cnt_next   = LAT_M1;
                end
            end
            S_WAIT: begin
                if (cnt_reg == 2'd0) begin
                    state_next   = S_RESP;
                    wb_we_next   = 1'b1;
                    wb_rd_next   = rd_reg;
                    wb_data_next = bus.ma_dataR;
                    wb_err_next  = ERR_OK;
                end else begin
                    cnt_next = cnt_reg - 2'd1;
                end
            end
            S_RESP: begin
                if (bus.wb_ready)
                    state_next = S_IDLE;
            end
            default: ;
        endcase

        // Accept overrides the RESP->IDLE retirement for back-to-back requests
        if (accept) begin
            store_next = bus.req_store;
            ctrl_next  = bus.req_ctrl;
            addr_next  = bus.req_addr;
            wdata_next = bus.req_wdata;
            rd_next    = bus.req_rd;
            if (req_err != ERR_OK) begin
                state_next   = S_RESP;
                wb_we_next   = 1'b0;
                wb_rd_next   = 5'd0;
                wb_data_next = 32'd0;
                wb_err_next  = req_err;
            end else begin
                state_next = S_ACCESS;
            end
        end

        if (bus.flush)
            state_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            store_reg   <= 1'b0;
            ctrl_reg    <= 3'd0;
            addr_reg    <= 32'd0;
            wdata_reg   <= 32'd0;
            rd_reg      <= 5'd0;
            cnt_reg     <= 2'd0;
            wb_we_reg   <= 1'b0;
            wb_rd_reg   <= 5'd0;
            wb_data_reg <= 32'd0;
            wb_err_reg  <= 2'd0;
        end else begin
            state_reg   <= state_next;
            store_reg   <= store_next;
            ctrl_reg    <= ctrl_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            rd_reg      <= rd_next;
            cnt_reg     <= cnt_next;
            wb_we_reg   <= wb_we_next;
            wb_rd_reg   <= wb_rd_next;
            wb_data_reg <= wb_data_next;
            wb_err_reg  <= wb_err_next;
        end
    end

    // Outputs are forced low during reset regardless of register contents
    assign in_access = (state_reg == S_ACCESS) && !rst;
    assign in_resp   = (state_reg == S_RESP) && !rst;

    assign bus.req_ready = req_ready_int;
    assign bus.ma_addr   = in_access ? addr_reg  : 32'd0;
    assign bus.ma_dataW  = in_access ? wdata_reg : 32'd0;
    assign bus.ma_ctrl   = in_access ? ctrl_reg  : 3'd0;
    assign bus.ma_memR   = in_access && !store_reg;
    assign bus.ma_memW   = in_access && store_reg;

    assign bus.wb_valid = in_resp;
    assign bus.wb_we    = in_resp && wb_we_reg;
    assign bus.wb_rd    = in_resp ? wb_rd_reg   : 5'd0;
    assign bus.wb_data  = in_resp ? wb_data_reg : 32'd0;
    assign bus.wb_err   = in_resp ? wb_err_reg  : 2'd0;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: one instance at READ_LAT=1 behind a small word
// memory, one at READ_LAT=3 (alignment off) fed by a cycle-stamped read pattern.
module tb_lsu_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   n_txn;
    logic [15:0] cyc;
    logic [15:0] memr_cyc;

    logic [31:0] mem [0:63];
    logic [31:0] rdata_q;

    lsu_ctrl_if bus1 ();
    lsu_ctrl_if bus3 ();

    lsu_ctrl #(.READ_LAT(1), .CHECK_ALIGN(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    lsu_ctrl #(.READ_LAT(3), .CHECK_ALIGN(1'b0)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus1.ma_memW)
            mem[bus1.ma_addr[7:2]] <= bus1.ma_dataW;
        rdata_q <= bus1.ma_memR ? mem[bus1.ma_addr[7:2]] : 32'h0;
    end
    assign bus1.ma_dataR = rdata_q;

    always @(posedge clk) begin
        if (rst) cyc <= 16'd0;
        else     cyc <= cyc + 16'd1;
    end
    assign bus3.ma_dataR = {16'hA5A5, cyc};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input string name);
        n_txn++;
        $display("txn %0d: %s", n_txn, name);
    endtask

    task automatic req1(input logic st, input logic [2:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
        bus1.req_valid = 1'b1;
        bus1.req_store = st;
        bus1.req_ctrl  = ctrl;
        bus1.req_addr  = addr;
        bus1.req_wdata = wdata;
        bus1.req_rd    = rd;
    endtask

    task automatic req3(input logic st, input logic [2:0] ctrl, input logic [31:0] addr,
                        input logic [4:0] rd);
        bus3.req_valid = 1'b1;
        bus3.req_store = st;
        bus3.req_ctrl  = ctrl;
        bus3.req_addr  = addr;
        bus3.req_wdata = 32'h0;
        bus3.req_rd    = rd;
    endtask

    task automatic check_quiet1(input string tag);
        check_eq({tag, ".wb_valid"}, 32'(bus1.wb_valid), 32'd0);
        check_eq({tag, ".memR"},     32'(bus1.ma_memR), 32'd0);
        check_eq({tag, ".memW"},     32'(bus1.ma_memW), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0; n_txn = 0;
        rst = 1'b1;
        bus1.flush = 1'b0; bus1.wb_ready = 1'b1;
        bus3.flush = 1'b0; bus3.wb_ready = 1'b1;
        req1(1'b0, 3'b010, 32'h0, 32'h0, 5'd1);
        req3(1'b0, 3'b010, 32'h0, 5'd1);

        // Reset held with req_valid high
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check_eq("rst.req_ready", 32'(bus1.req_ready), 32'd0);
            check_eq("rst.ma_addr",   bus1.ma_addr, 32'd0);
            check_eq("rst.wb_data",   bus1.wb_data, 32'd0);
            check_eq("rst.req_ready3", 32'(bus3.req_ready), 32'd0);
            check_quiet1("rst");
        end
        step();
        rst = 1'b0;
        bus1.req_valid = 1'b0;
        bus3.req_valid = 1'b0;
        @(negedge clk);
        check_eq("post_rst.req_ready", 32'(bus1.req_ready), 32'd1);
        txn("reset");

        // sw 0x10 <- DEADBEEF
        step();
        req1(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0);
        @(negedge clk);
        check_eq("sw.accept", 32'(bus1.req_ready), 32'd1);
        step();
        bus1.req_valid = 1'b0;
        @(negedge clk);
        check_eq("sw.memW",  32'(bus1.ma_memW), 32'd1);
        check_eq("sw.memR",  32'(bus1.ma_memR), 32'd0);
        check_eq("sw.addr",  bus1.ma_addr, 32'h10);
        check_eq("sw.dataW", bus1.ma_dataW, 32'hDEADBEEF);
        check_eq("sw.ctrl",  32'(bus1.ma_ctrl), 32'd2);
        step();
        @(negedge clk);
        check_eq("sw.wb_valid", 32'(bus1.wb_valid), 32'd1);
        check_eq("sw.wb_we",    32'(bus1.wb_we), 32'd0);
        check_eq("sw.wb_err",   32'(bus1.wb_err), 32'd0);
        check_eq("sw.memW_off", 32'(bus1.ma_memW), 32'd0);
        txn("sw 0x10");

        // lw x5 <- 0x10, result 3 cycles after accept
        step();
        req1(1'b0, 3'b010, 32'h10, 32'h0, 5'd5);
        @(negedge clk);
        check_eq("lw.accept", 32'(bus1.req_ready), 32'd1);
        step();
        bus1.req_valid = 1'b0;
        @(negedge clk);
        check_eq("lw.memR", 32'(bus1.ma_memR), 32'd1);
        check_eq("lw.memW", 32'(bus1.ma_memW), 32'd0);
        step();
        @(negedge clk);
        check_quiet1("lw.wait");
        step();
        @(negedge clk);
        check_eq("lw.wb_valid", 32'(bus1.wb_valid), 32'd1);
        check_eq("lw.wb_data",  bus1.wb_data, 32'hDEADBEEF);
        check_eq("lw.wb_rd",    32'(bus1.wb_rd), 32'd5);
        check_eq("lw.wb_we",    32'(bus1.wb_we), 32'd1);
        txn("lw x5 0x10");

        // lh at odd address -> misaligned, no strobe
        step();
        req1(1'b0, 3'b001, 32'h3, 32'h0, 5'd6);
        @(negedge clk);
        check_quiet1("lh.acc");
        step();
        bus1.req_valid = 1'b0;
        @(negedge clk);
        check_eq("lh.wb_valid", 32'(bus1.wb_valid), 32'd1);
        check_eq("lh.wb_err",   32'(bus1.wb_err), 32'd1);
        check_eq("lh.wb_we",    32'(bus1.wb_we), 32'd0);
        check_eq("lh.wb_rd",    32'(bus1.wb_rd), 32'd0);
        check_eq("lh.memR",     32'(bus1.ma_memR), 32'd0);
        txn("lh 0x3 misaligned");

        // store with ctrl=100 -> illegal
        step();
        req1(1'b1, 3'b100, 32'h20, 32'h1, 5'd0);
        step();
        bus1.req_valid = 1'b0;
        @(negedge clk);
        check_eq("sbu.wb_valid", 32'(bus1.wb_valid), 32'd1);
        check_eq("sbu.wb_err",   32'(bus1.wb_err), 32'd2);
        check_eq("sbu.memW",     32'(bus1.ma_memW), 32'd0);
        txn("store ctrl=100 illegal");

        // load held under WB backpressure, then back-to-back accept
        step();
        bus1.wb_ready = 1'b0;
        req1(1'b0, 3'b010, 32'h10, 32'h0, 5'd7);
        step();
        bus1.req_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("hold.wb_valid",  32'(bus1.wb_valid), 32'd1);
            check_eq("hold.wb_data",   bus1.wb_data, 32'hDEADBEEF);
            check_eq("hold.wb_rd",     32'(bus1.wb_rd), 32'd7);
            check_eq("hold.req_ready", 32'(bus1.req_ready), 32'd0);
            step();
        end
        bus1.wb_ready = 1'b1;
        req1(1'b1, 3'b010, 32'h14, 32'h12345678, 5'd0);
        @(negedge clk);
        check_eq("b2b.wb_valid",  32'(bus1.wb_valid), 32'd1);
        check_eq("b2b.req_ready", 32'(bus1.req_ready), 32'd1);
        txn("lw x7 held 4 cycles");
        step();
        bus1.req_valid = 1'b0;
        @(negedge clk);
        check_eq("b2b.memW",     32'(bus1.ma_memW), 32'd1);
        check_eq("b2b.addr",     bus1.ma_addr, 32'h14);
        check_eq("b2b.wb_valid0", 32'(bus1.wb_valid), 32'd0);
        step();
        @(negedge clk);
        check_eq("b2b.done", 32'(bus1.wb_valid), 32'd1);
        txn("sw 0x14 back-to-back");

        // flush during load WAIT
        step();
        req1(1'b0, 3'b010, 32'h10, 32'h0, 5'd3);
        step();
        bus1.req_valid = 1'b0;
        step();
        bus1.flush = 1'b1;
        @(negedge clk);
        check_eq("flw.req_ready", 32'(bus1.req_ready), 32'd0);
        step();
        bus1.flush = 1'b0;
        @(negedge clk);
        check_eq("flw.wb_valid",  32'(bus1.wb_valid), 32'd0);
        check_eq("flw.req_ready", 32'(bus1.req_ready), 32'd1);
        step();
        @(negedge clk);
        check_eq("flw.wb_valid2", 32'(bus1.wb_valid), 32'd0);
        txn("lw flushed in WAIT");

        // flush during store ACCESS: strobe still seen, no completion
        step();
        req1(1'b1, 3'b010, 32'h18, 32'hCAFEF00D, 5'd0);
        step();
        bus1.req_valid = 1'b0;
        bus1.flush = 1'b1;
        @(negedge clk);
        check_eq("fls.memW", 32'(bus1.ma_memW), 32'd1);
        step();
        bus1.flush = 1'b0;
        @(negedge clk);
        check_eq("fls.wb_valid", 32'(bus1.wb_valid), 32'd0);
        check_eq("fls.memW_off", 32'(bus1.ma_memW), 32'd0);
        txn("sw 0x18 flushed in ACCESS");

        // flushed store did commit
        step();
        req1(1'b0, 3'b010, 32'h18, 32'h0, 5'd9);
        step();
        bus1.req_valid = 1'b0;
        step();
        step();
        @(negedge clk);
        check_eq("commit.wb_data", bus1.wb_data, 32'hCAFEF00D);
        txn("lw x9 0x18");

        // READ_LAT=3 lbu: captured data is the pattern 3 cycles after memR
        step();
        req3(1'b0, 3'b100, 32'h1, 5'd9);
        step();
        bus3.req_valid = 1'b0;
        @(negedge clk);
        check_eq("lbu.memR", 32'(bus3.ma_memR), 32'd1);
        memr_cyc = cyc;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check_eq("lbu.wait_valid", 32'(bus3.wb_valid), 32'd0);
        end
        step();
        @(negedge clk);
        check_eq("lbu.wb_valid", 32'(bus3.wb_valid), 32'd1);
        check_eq("lbu.wb_data",  bus3.wb_data, {16'hA5A5, memr_cyc + 16'd3});
        check_eq("lbu.wb_rd",    32'(bus3.wb_rd), 32'd9);
        txn("lbu READ_LAT=3");

        // Alignment checking disabled: unaligned lw goes to MA
        step();
        req3(1'b0, 3'b010, 32'h2, 5'd1);
        step();
        bus3.req_valid = 1'b0;
        @(negedge clk);
        check_eq("noal.memR", 32'(bus3.ma_memR), 32'd1);
        check_eq("noal.addr", bus3.ma_addr, 32'h2);
        for (int i = 0; i < 4; i++) step();
        @(negedge clk);
        check_eq("noal.wb_valid", 32'(bus3.wb_valid), 32'd1);
        check_eq("noal.wb_err",   32'(bus3.wb_err), 32'd0);
        txn("lw 0x2 no align check");

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer directly upstream of the MA (memory access) stage.
- Accepts one memory request at a time from EX over a valid/ready handshake and checks ctrl legality and address alignment.
- Drives the MA stage's addr/dataW/mem_ctrl/memR/memW for exactly one cycle, waits out the data-memory read latency, and holds the load result (or store completion / error) for WB until WB accepts it.

Parameters:
READ_LAT, 1, cycles from the ma_memR cycle to ma_dataR valid; legal 1..4
CHECK_ALIGN, 1, 1 enables misalignment detection; 0 passes any address to MA

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset (see Behaviour)
flush  in  1  kill the in-flight request and its result
req_valid  in  1  EX request valid
req_ready  out  1  block can accept a request
req_store  in  1  1 = store, 0 = load
req_ctrl  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
req_addr  in  32  byte address
req_wdata  in  32  store data, LSB-aligned
req_rd  in  5  load destination register
ma_addr  out  32  to MA addr
ma_dataW  out  32  to MA dataW
ma_ctrl  out  3  to MA mem_ctrl
ma_memR  out  1  to MA memR
ma_memW  out  1  to MA memW
ma_dataR  in  32  from MA dataR; already lane-selected and extended by MA
wb_valid  out  1  result valid
wb_ready  in  1  WB accepts the result
wb_we  out  1  1 = write wb_data to wb_rd
wb_rd  out  5  destination register
wb_data  out  32  load data
wb_err  out  2  00 ok, 01 misaligned, 10 illegal ctrl

Behaviour:
- Reset is synchronous and active-high. While rst is high, all outputs are 0 (req_ready included) and the state is IDLE. rst wins over every other input in every state; a request aborted mid-flight produces no wb_valid.
- States: IDLE, ACCESS, WAIT, RESP.
- req_ready = (IDLE or (RESP and wb_ready)) and !flush and !rst.
- Accept = req_valid and req_ready. On accept, latch store, ctrl, addr, wdata and rd.
- Illegal ctrl: store with ctrl not in {000, 001, 010}; load with ctrl in {011, 110, 111}. Checked before alignment.
- Misaligned (CHECK_ALIGN=1 only): h/hu with addr[0]=1; w with addr[1:0]!=00.
- Transitions on accept:
  - Error -> RESP with wb_err set, wb_we=0, wb_data=0. No memory strobe is ever raised.
  - Otherwise -> ACCESS.
- ACCESS (exactly 1 cycle): ma_addr, ma_dataW, ma_ctrl driven from the latches; ma_memR = !store, ma_memW = store.
  - Store -> RESP with wb_we=0.
  - Load -> WAIT, counter loaded with READ_LAT-1.
- WAIT: strobes 0. Count down; when the count is 0, capture ma_dataR into wb_data and go to RESP with wb_we=1 and wb_rd = latched rd. Total load latency from the accept cycle to first wb_valid is READ_LAT+2 cycles.
- RESP: wb_valid=1. wb_we/wb_rd/wb_data/wb_err are held stable until wb_valid and wb_ready.
  - On handshake with no new accept -> IDLE.
  - On handshake with a same-cycle accept, the next request is processed per the accept rules (back-to-back).
- ma_addr, ma_dataW and ma_ctrl are 0 outside ACCESS; ma_memR and ma_memW are never high together.
- flush (synchronous, below rst):
  - Next state is IDLE from any state; wb_valid drops the next cycle; no new accept that cycle.
  - A strobe already high in the flush cycle still reaches MA that cycle, i.e. a store in ACCESS commits.
  - A WB handshake in the same cycle as flush is still counted by WB; the block only clears.
- wb_rd = 0 whenever wb_we = 0.

Test Plan:
- Reset held 3 cycles with req_valid=1 -> all outputs 0 throughout; req_ready=1 on the first cycle after rst falls.
- Store sw addr=0x10 wdata=0xDEADBEEF, then lw addr=0x10 rd=5, READ_LAT=1, wb_ready=1 -> ma_memW one cycle, ma_memR one cycle; load wb_valid 3 cycles after its accept with wb_data=0xDEADBEEF, wb_rd=5, wb_we=1.
- lh addr=0x3 -> RESP one cycle after accept, wb_err=01, wb_we=0, ma_memR/ma_memW never high. Store with ctrl=100 -> wb_err=10.
- Load with wb_ready=0 for 4 cycles -> wb_valid held, wb_data stable, req_ready=0. Then wb_ready=1 with a new req_valid -> handshake and new accept in the same cycle.
- READ_LAT=3 lbu -> exactly 2 WAIT cycles beyond the first; captured data equals ma_dataR of the cycle 3 after ma_memR.
- flush asserted in the WAIT cycle of a load -> no wb_valid; IDLE the next cycle. flush in a store's ACCESS cycle -> ma_memW seen high once; no completion reported.
